// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address, byte writes and byte reads.
// Define I2C_SLAVE_CLOCK_STRETCH_EN to stretch scl until tx_valid on reads.
module i2c_slave #(
  parameter logic [6:0] ADDRESS = 7'h50
) (
  input  logic       clk_in,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  input  logic [7:0] data_tx,
  input  logic       tx_valid,
  output logic       tx_request,
  output logic       selected,
  output logic       controller_nack
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [1:0] scl_s, sda_s;
  logic       scl_d, sda_d;
  logic [1:0] warm_q;
  logic       armed;
  logic       scl_rise, scl_fall;
  logic       bus_start, bus_stop;
  logic       sda_in;

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] txsh_q, txsh_d;
  logic [7:0] data_rx_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       scl_oe_q, scl_oe_d;
  logic       pend_q, pend_d;
  logic       rx_valid_d, tx_req_d, sel_d, nack_d;
  logic       load_tx;

  assign sda = sda_oe_q ? 1'b0 : 1'bz;
  assign scl = scl_oe_q ? 1'b0 : 1'bz;

`ifndef I2C_SLAVE_CLOCK_STRETCH_EN
  logic unused_tx_valid;
  assign unused_tx_valid = tx_valid;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      scl_s  <= 2'b11;
      sda_s  <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
      warm_q <= 2'd0;
    end else begin
      scl_s <= {scl_s[0], scl};
      sda_s <= {sda_s[0], sda};
      scl_d <= scl_s[1];
      sda_d <= sda_s[1];
      if (!armed) warm_q <= warm_q + 2'd1;
    end
  end

  // Bus events are masked until the pipeline holds real bus values,
  // so a START already in progress at reset release is not seen.
  assign armed     = (warm_q == 2'd3);
  assign sda_in    = sda_s[1];
  assign scl_rise  = scl_s[1] & ~scl_d;
  assign scl_fall  = ~scl_s[1] & scl_d;
  assign bus_start = armed & scl_s[1] & scl_d & sda_d & ~sda_s[1];
  assign bus_stop  = armed & scl_s[1] & scl_d & ~sda_d & sda_s[1];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      shreg_q         <= 8'h00;
      txsh_q          <= 8'h00;
      rw_q            <= 1'b0;
      sda_oe_q        <= 1'b0;
      scl_oe_q        <= 1'b0;
      pend_q          <= 1'b0;
      data_rx         <= 8'h00;
      rx_valid        <= 1'b0;
      tx_request      <= 1'b0;
      selected        <= 1'b0;
      controller_nack <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shreg_q         <= shreg_d;
      txsh_q          <= txsh_d;
      rw_q            <= rw_d;
      sda_oe_q        <= sda_oe_d;
      scl_oe_q        <= scl_oe_d;
      pend_q          <= pend_d;
      data_rx         <= data_rx_d;
      rx_valid        <= rx_valid_d;
      tx_request      <= tx_req_d;
      selected        <= sel_d;
      controller_nack <= nack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    txsh_d     = txsh_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    pend_d     = pend_q;
    data_rx_d  = data_rx;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    sel_d      = selected;
    nack_d     = 1'b0;
    load_tx    = 1'b0;

    if (bus_stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      pend_d   = 1'b0;
      sel_d    = 1'b0;
    end else if (bus_start) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      pend_d   = 1'b0;
      sel_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_in};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rw_d  = sda_in;
              cnt_d = 4'd0;
              if (shreg_q[6:0] == ADDRESS) begin
                state_d = ADDR_ACK;
                sel_d   = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        // cnt 0: waiting for the 8th fall, cnt 1: ACK bit on the bus
        ADDR_ACK, WRITE_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_oe_d = 1'b1;
              cnt_d    = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d  = READ;
                tx_req_d = 1'b1;
                load_tx  = 1'b1;
              end else begin
                state_d = WRITE;
              end
            end
          end
        end
        WRITE: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_in};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              data_rx_d  = {shreg_q[6:0], sda_in};
              rx_valid_d = 1'b1;
              state_d    = WRITE_ACK;
              cnt_d      = 4'd0;
            end
          end
        end
        READ: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              state_d = READ_ACK;
              cnt_d   = 4'd0;
            end
          end else if (scl_fall && !pend_q) begin
            txsh_d   = {txsh_q[6:0], 1'b0};
            sda_oe_d = ~txsh_q[6];
          end
        end
        // cnt 0: release for bit 9, 1: sample ACK, 2: wait final fall
        READ_ACK: begin
          if (cnt_q == 4'd0 && scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd1;
          end else if (cnt_q == 4'd1 && scl_rise) begin
            if (sda_in) begin
              nack_d  = 1'b1;
              state_d = IGNORE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = 4'd2;
            end
          end else if (cnt_q == 4'd2 && scl_fall) begin
            state_d  = READ;
            cnt_d    = 4'd0;
            tx_req_d = 1'b1;
            load_tx  = 1'b1;
          end
        end
      endcase

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
      if (load_tx) begin
        pend_d   = 1'b1;
        scl_oe_d = 1'b1;
      end
      if (pend_q && tx_valid) begin
        pend_d   = 1'b0;
        scl_oe_d = 1'b0;
        txsh_d   = data_tx;
        sda_oe_d = ~data_tx[7];
      end
`else
      if (load_tx) begin
        txsh_d   = data_tx;
        sda_oe_d = ~data_tx[7];
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged controller, transaction-level model.
module tb_i2c_slave;

  localparam logic [6:0] ADDR = 7'h50;
  localparam int LIM = 3000;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  wire  scl, sda;
  logic m_scl_low = 1'b0;
  logic m_sda_low = 1'b0;
  logic [7:0] data_rx;
  logic [7:0] data_tx = 8'h00;
  logic rx_valid, tx_request, selected, controller_nack;
  logic tx_valid = 1'b1;

  int checks = 0;
  int errors = 0;
  int n_rx = 0, n_txr = 0, n_nack = 0;
  int low_run = 0, max_low = 0;
  logic [7:0] m_rx = 8'h00;
  int m_nrx = 0, m_ntxr = 0, m_nnack = 0;

  pullup (scl);
  pullup (sda);
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave #(.ADDRESS(ADDR)) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .scl             (scl),
    .sda             (sda),
    .data_rx         (data_rx),
    .rx_valid        (rx_valid),
    .data_tx         (data_tx),
    .tx_valid        (tx_valid),
    .tx_request      (tx_request),
    .selected        (selected),
    .controller_nack (controller_nack)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (rx_valid === 1'b1) n_rx++;
    if (tx_request === 1'b1) n_txr++;
    if (controller_nack === 1'b1) n_nack++;
    if (scl === 1'b0) low_run++;
    else low_run = 0;
    if (low_run > max_low) max_low = low_run;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic scl_high(output int w);
    m_scl_low = 1'b0;
    w = 0;
    while (scl !== 1'b1 && w < LIM) begin
      cyc(1);
      w++;
    end
    if (w >= LIM) begin
      checks++;
      errors++;
      $error("FAIL scl_release: waited %0d cycles, limit %0d", w, LIM);
    end
  endtask

  task automatic put_bit(input logic b);
    int w;
    cyc(4);
    m_sda_low = ~b;
    cyc(8);
    scl_high(w);
    cyc(12);
    m_scl_low = 1'b1;
  endtask

  task automatic get_bit(output logic b);
    int w;
    cyc(4);
    m_sda_low = 1'b0;
    cyc(8);
    scl_high(w);
    cyc(6);
    b = sda;
    cyc(6);
    m_scl_low = 1'b1;
  endtask

  task automatic start_c();
    int w;
    cyc(4);
    m_sda_low = 1'b0;
    cyc(8);
    scl_high(w);
    cyc(8);
    m_sda_low = 1'b1;
    cyc(8);
    m_scl_low = 1'b1;
  endtask

  task automatic stop_c();
    int w;
    cyc(4);
    m_sda_low = 1'b1;
    cyc(8);
    scl_high(w);
    cyc(8);
    m_sda_low = 1'b0;
    cyc(12);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack,
                           input logic [7:0] next_tx);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      get_bit(bit_v);
      b[i] = bit_v;
    end
    data_tx = next_tx;
    put_bit(nack);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_data_rx"}, data_rx, m_rx);
    chk({tag, "_rx_pulses"}, n_rx, m_nrx);
    chk({tag, "_tx_requests"}, n_txr, m_ntxr);
    chk({tag, "_nack_pulses"}, n_nack, m_nnack);
  endtask

  // One controller transaction; the model derives every expectation
  // from the address match and the transfer direction alone.
  task automatic xfer(input logic [7:0] ab, input int n,
                      input logic [3:0][7:0] d, input logic do_stop);
    logic hit, ack;
    logic [7:0] b;
    hit = (ab[7:1] == ADDR);
    if (ab[0]) data_tx = d[0];
    start_c();
    write_byte(ab, ack);
    chk("addr_ack", ack, !hit);
    chk("selected", selected, hit);
    for (int k = 0; k < n; k++) begin
      if (!ab[0]) begin
        write_byte(d[k], ack);
        chk("data_ack", ack, !hit);
        if (hit) begin
          m_rx = d[k];
          m_nrx++;
        end
      end else begin
        read_byte(b, (k == n - 1), d[k + 1]);
        chk("read_byte", b, hit ? d[k] : 8'hFF);
        if (hit) m_ntxr++;
      end
    end
    if (ab[0] && hit) m_nnack++;
    if (do_stop) begin
      stop_c();
      chk("sel_after_stop", selected, 1'b0);
    end
    cyc(4);
    check_counts("xfer");
  endtask

  initial begin
    logic ack;
    logic [3:0][7:0] d;
    logic [6:0] a7;
    logic rw;

    cyc(3);
    chk("rst_sda", sda, 1'b1);
    chk("rst_scl", scl, 1'b1);
    chk("rst_data_rx", data_rx, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_request", tx_request, 1'b0);
    chk("rst_selected", selected, 1'b0);
    chk("rst_nack", controller_nack, 1'b0);

    // START already in progress when reset is released
    m_sda_low = 1'b1;
    cyc(4);
    reset = 1'b0;
    cyc(10);
    m_scl_low = 1'b1;
    write_byte(8'hA0, ack);
    chk("ign_start_ack", ack, 1'b1);
    chk("ign_start_sel", selected, 1'b0);
    stop_c();
    check_counts("ign_start");

    d = '0;
    d[0] = 8'h3C;
    xfer(8'hA0, 1, d, 1'b1);
    xfer(8'hA2, 1, d, 1'b1);
    d[0] = 8'h96;
    d[1] = 8'h5A;
    xfer(8'hA1, 2, d, 1'b1);
    d[0] = 8'h11;
    xfer(8'hA0, 1, d, 1'b0);
    d[0] = 8'($urandom);
    xfer(8'hA1, 1, d, 1'b1);

    for (int t = 0; t < 8; t++) begin
      a7 = $urandom_range(0, 1) ? ADDR : 7'($urandom);
      rw = 1'($urandom);
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      xfer({a7, rw}, $urandom_range(1, 3), d, $urandom_range(0, 3) != 0);
    end
    stop_c();

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    begin
      int base;
      logic [7:0] b;
      base = n_txr;
      tx_valid = 1'b0;
      d[0] = 8'($urandom);
      data_tx = d[0];
      fork
        begin
          for (int k = 0; k < 5000 && n_txr == base; k++) cyc(1);
          cyc(200);
          tx_valid = 1'b1;
        end
      join_none
      start_c();
      write_byte(8'hA1, ack);
      chk("st_addr_ack", ack, 1'b0);
      max_low = 0;
      read_byte(b, 1'b1, 8'h00);
      chk("st_byte", b, d[0]);
      chk("st_held", (max_low >= 200), 1'b1);
      stop_c();
      m_ntxr++;
      m_nnack++;
      cyc(4);
      check_counts("stretch");
    end
`endif

    // reset in the middle of a written byte
    start_c();
    write_byte(8'hA0, ack);
    chk("mid_addr_ack", ack, 1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b1);
    m_sda_low = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    chk("mid_sda", sda, 1'b1);
    chk("mid_data_rx", data_rx, 8'h00);
    chk("mid_rx_valid", rx_valid, 1'b0);
    chk("mid_tx_request", tx_request, 1'b0);
    chk("mid_selected", selected, 1'b0);
    chk("mid_nack", controller_nack, 1'b0);
    m_rx = 8'h00;
    m_scl_low = 1'b0;
    cyc(4);
    reset = 1'b0;
    cyc(10);
    d[0] = 8'($urandom);
    xfer(8'hA0, 1, d, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
